// File: rtl/int_to_float_seq.sv
// Sequential signed-integer to packed-float converter {s, exposant, mantisse}.
// It normalises one bit per cycle and truncates the mantissa without rounding.
module int_to_float_seq #(
  parameter int NM = 23,
  parameter int NE = 8,
  parameter int NI = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [NI-1:0]    in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [NE+NM:0]   out_float_o,
  output logic             out_inexact_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid, once raised, is held with stable data until that transfer.

  localparam int          BIAS     = 2**(NE-1) - 1;
  localparam logic [NE:0] EXP_INIT = (NE+1)'(BIAS + NI - 1);
  localparam logic [NE:0] EXP_SAT  = (NE+1)'(2**NE - 1);
  localparam int          W        = NI - 1 + NM;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic [NI-1:0]   mag_q, mag_d;
  logic [NE:0]     exp_q, exp_d;
  logic [NE+NM:0]  float_q, float_d;
  logic            inexact_q, inexact_d;

  logic [NI-1:0]   abs_in;
  logic [W-1:0]    ext;
  logic [NM-1:0]   mant;
  logic            dropped;

  assign abs_in = in_data_i[NI-1] ? (~in_data_i + NI'(1)) : in_data_i;

  // The hidden leading one is dropped; zero padding covers the case NI-1 < NM.
  assign ext     = {mag_q[NI-2:0], {NM{1'b0}}};
  assign mant    = ext[W-1 -: NM];
  assign dropped = |ext[NI-2:0];

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    float_d   = float_q;
    inexact_d = inexact_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sign_d  = in_data_i[NI-1];
          mag_d   = abs_in;
          exp_d   = EXP_INIT;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          float_d   = '0;
          inexact_d = 1'b0;
          state_d   = DONE;
        end else if (mag_q[NI-1]) begin
          if (exp_q >= EXP_SAT) begin
            float_d = {sign_q, {NE{1'b1}}, {NM{1'b0}}};
          end else begin
            float_d = {sign_q, exp_q[NE-1:0], mant};
          end
          inexact_d = dropped;
          state_d   = DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - (NE+1)'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      float_q   <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      float_q   <= float_d;
      inexact_q <= inexact_d;
    end
  end

  assign in_ready_o    = (state_q == IDLE);
  assign out_valid_o   = (state_q == DONE);
  assign out_float_o   = float_q;
  assign out_inexact_o = inexact_q;

endmodule

// File: tb/tb_int_to_float_seq.sv
// Bench for int_to_float_seq: directed corner values, random values against an
// arithmetic float model, backpressure and asynchronous reset.
module tb_int_to_float_seq;

  localparam int NM = 23;
  localparam int NE = 8;
  localparam int NI = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NI-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_float;
  logic          out_inexact;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int_to_float_seq #(.NM(NM), .NE(NE), .NI(NI)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_float_o   (out_float),
    .out_inexact_o (out_inexact)
  );

  always #5 clk = ~clk;

  // Reference: value = (-1)^s * 1.f * 2^e, exponent biased by 127, f truncated.
  task automatic model(input logic [31:0] d, output logic [31:0] f,
                       output logic ix, output int lat);
    longint v, m, frac;
    int e;
    v = longint'($signed(d));
    m = (v < 0) ? -v : v;
    if (m == 0) begin
      f = 32'h0; ix = 1'b0; lat = 1;
    end else begin
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      frac = m - (longint'(1) << e);
      f[31]    = (v < 0);
      f[30:23] = 8'(127 + e);
      if (e >= 23) begin
        f[22:0] = 23'(frac >> (e - 23));
        ix = ((frac & ((longint'(1) << (e - 23)) - 1)) != 0);
      end else begin
        f[22:0] = 23'(frac << (23 - e));
        ix = 1'b0;
      end
      lat = 32 - e;
    end
  endtask

  // Launches one conversion and waits (bounded) for out_valid; leaves the
  // result pending in DONE. lat = -1 signals a timeout.
  task automatic start_and_wait(input logic [31:0] d, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic finish_xfer();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [31:0] d);
    logic [31:0] ef;
    logic        eix;
    int          elat, lat;
    model(d, ef, eix, elat);
    start_and_wait(d, lat);
    total_cnt++;
    if (lat !== elat) $display("FAIL %s latency in=%h got=%0d exp=%0d", name, d, lat, elat);
    else pass_cnt++;
    total_cnt++;
    if (out_float !== ef) $display("FAIL %s float in=%h got=%h exp=%h", name, d, out_float, ef);
    else pass_cnt++;
    total_cnt++;
    if (out_inexact !== eix) $display("FAIL %s inexact in=%h got=%b exp=%b", name, d, out_inexact, eix);
    else pass_cnt++;
    finish_xfer();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s after_xfer valid=%b ready=%b exp valid=0 ready=1", name, out_valid, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_float !== ef) $display("FAIL %s hold got=%h exp=%h", name, out_float, ef);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_float !== 32'h0 || out_inexact !== 1'b0)
      $display("FAIL reset ready=%b valid=%b float=%h ix=%b exp 1 0 0 0",
               in_ready, out_valid, out_float, out_inexact);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] vals [8];
    vals = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
             32'h0100_0001, 32'h00FF_FFFF, 32'h7FFF_FFFF, 32'h0000_0003};
    foreach (vals[i]) run_one("directed", vals[i]);
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = -d;
      run_one("random", d);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ef;
    logic        eix;
    int          elat, lat;
    model(32'd5, ef, eix, elat);
    start_and_wait(32'd5, lat);
    total_cnt++;
    if (lat !== elat) $display("FAIL bp latency got=%0d exp=%0d", lat, elat);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_float !== ef)
        $display("FAIL bp hold valid=%b ready=%b float=%h exp 1 0 %h", out_valid, in_ready, out_float, ef);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    finish_xfer();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp release valid=%b ready=%b exp 0 1", out_valid, in_ready);
    else pass_cnt++;
    // No stray input may have been captured while busy.
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp no_extra valid=%b ready=%b exp 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_data  = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_float !== 32'h0)
      $display("FAIL async_rst valid=%b ready=%b float=%h exp 0 1 0", out_valid, in_ready, out_float);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_one("after_rst", 32'd3);
    total_cnt++;
    if (out_float !== 32'h4040_0000) $display("FAIL after_rst const got=%h exp=40400000", out_float);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
